// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-path definitions: opcodes, funct3 width codes, LSU states.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // Encodings with no defined width for the given access direction.
  function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
    if (is_load) return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    return f3 > 3'b010;
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      f3,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] ldata_c,
  output logic            misalign_c
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  assign byte_sh = rdata >> {off, 3'b000};
  assign half_sh = rdata >> {off[1], 4'b0000};

  // Store side: width comes from the low two funct3 bits only.
  always_comb begin
    be_c       = 4'b0000;
    wdata_c    = '0;
    misalign_c = 1'b0;
    case (f3[1:0])
      2'b00: begin
        be_c    = 4'(4'b0001 << off);
        wdata_c = {4{rs2[7:0]}};
      end
      2'b01: begin
        be_c       = 4'(4'b0011 << {off[1], 1'b0});
        wdata_c    = {2{rs2[15:0]}};
        misalign_c = off[0];
      end
      2'b10: begin
        be_c       = 4'b1111;
        wdata_c    = rs2;
        misalign_c = (off != 2'b00);
      end
      default: ;
    endcase
  end

  always_comb begin
    ldata_c = '0;
    case (f3)
      F3_B:    ldata_c = {{24{byte_sh[7]}}, byte_sh[7:0]};
      F3_BU:   ldata_c = {24'h000000, byte_sh[7:0]};
      F3_H:    ldata_c = {{16{half_sh[15]}}, half_sh[15:0]};
      F3_HU:   ldata_c = {16'h0000, half_sh[15:0]};
      F3_W:    ldata_c = rdata;
      default: ldata_c = '0;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: one bus transaction at a time, in-order registered write-back.
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [4:0]      i_rd,
  output logic            o_mem_req,
  input  logic            i_mem_gnt,
  output logic            o_mem_we,
  output logic [3:0]      o_mem_be,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_wb_valid,
  output logic            o_wb_we,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_err
);

  lsu_state_t state_q, state_d;

  logic [2:0] cap_f3_q, cap_f3_d;
  logic [1:0] cap_off_q, cap_off_d;
  logic [4:0] cap_rd_q, cap_rd_d;
  logic       cap_load_q, cap_load_d;

  logic            mem_req_d, mem_we_d;
  logic [3:0]      mem_be_d;
  logic [XLEN-1:0] mem_addr_d, mem_wdata_d;
  logic            wb_valid_d, wb_we_d, err_d;
  logic [4:0]      wb_rd_d;
  logic [XLEN-1:0] wb_data_d;

  logic            accept, is_load, is_store, is_mem, fault;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_ldata;
  logic            al_misalign;

  assign accept   = i_valid & o_ready;
  assign is_load  = (i_opcode == OP_LOAD);
  assign is_store = (i_opcode == OP_STORE);
  assign is_mem   = is_load | is_store;

  // Aligner sees live inputs while idle, captured fields once a transaction is open.
  assign al_f3  = (state_q == IDLE) ? i_funct3 : cap_f3_q;
  assign al_off = (state_q == IDLE) ? i_addr[1:0] : cap_off_q;

  riscv_lsu_align u_align (
    .f3         (al_f3),
    .off        (al_off),
    .rs2        (i_wdata),
    .rdata      (i_mem_rdata),
    .be_c       (al_be),
    .wdata_c    (al_wdata),
    .ldata_c    (al_ldata),
    .misalign_c (al_misalign)
  );

  assign fault = is_mem & (al_misalign | f3_illegal(is_load, i_funct3));

  always_comb begin
    state_d     = state_q;
    cap_f3_d    = cap_f3_q;
    cap_off_d   = cap_off_q;
    cap_rd_d    = cap_rd_q;
    cap_load_d  = cap_load_q;
    mem_req_d   = o_mem_req;
    mem_we_d    = o_mem_we;
    mem_be_d    = o_mem_be;
    mem_addr_d  = o_mem_addr;
    mem_wdata_d = o_mem_wdata;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = o_wb_rd;
    wb_data_d   = o_wb_data;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mem && !fault) begin
            state_d     = REQ;
            cap_f3_d    = i_funct3;
            cap_off_d   = i_addr[1:0];
            cap_rd_d    = i_rd;
            cap_load_d  = is_load;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store;
            mem_be_d    = al_be;
            mem_addr_d  = {i_addr[XLEN-1:2], 2'b00};
            mem_wdata_d = is_store ? al_wdata : '0;
          end else begin
            wb_valid_d = 1'b1;
            wb_rd_d    = i_rd;
            if (fault) begin
              err_d     = 1'b1;
              wb_data_d = '0;
            end else begin
              wb_we_d   = (i_rd != 5'd0);
              wb_data_d = i_addr;
            end
          end
        end
      end
      REQ: begin
        if (i_mem_gnt) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (cap_load_q) begin
            state_d = WAIT;
          end else begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_rd_d    = cap_rd_q;
            wb_data_d  = '0;
          end
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = (cap_rd_q != 5'd0);
          wb_rd_d    = cap_rd_q;
          wb_data_d  = al_ldata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cap_f3_q    <= 3'd0;
      cap_off_q   <= 2'd0;
      cap_rd_q    <= 5'd0;
      cap_load_q  <= 1'b0;
      o_ready     <= 1'b1;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_be    <= 4'd0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_wb_valid  <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_rd     <= 5'd0;
      o_wb_data   <= '0;
      o_err       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_f3_q    <= cap_f3_d;
      cap_off_q   <= cap_off_d;
      cap_rd_q    <= cap_rd_d;
      cap_load_q  <= cap_load_d;
      o_ready     <= (state_d == IDLE);
      o_mem_req   <= mem_req_d;
      o_mem_we    <= mem_we_d;
      o_mem_be    <= mem_be_d;
      o_mem_addr  <= mem_addr_d;
      o_mem_wdata <= mem_wdata_d;
      o_wb_valid  <= wb_valid_d;
      o_wb_we     <= wb_we_d;
      o_wb_rd     <= wb_rd_d;
      o_wb_data   <= wb_data_d;
      o_err       <= err_d;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with hand-computed expected values.
module tb_riscv_lsu;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_ADD   = 7'b0110011;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd;
  logic        o_mem_req;
  logic        i_mem_gnt;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic        o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_err;

  int errors = 0;
  int checks = 0;

  riscv_lsu dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_opcode     (i_opcode),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_rd         (i_rd),
    .o_mem_req    (o_mem_req),
    .i_mem_gnt    (i_mem_gnt),
    .o_mem_we     (o_mem_we),
    .o_mem_be     (o_mem_be),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_wb_valid   (o_wb_valid),
    .o_wb_we      (o_wb_we),
    .o_wb_rd      (o_wb_rd),
    .o_wb_data    (o_wb_data),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    i_valid  = 1'b1;
    i_opcode = op;
    i_funct3 = f3;
    i_addr   = addr;
    i_wdata  = wd;
    i_rd     = rd;
  endtask

  // Load with immediate grant and rvalid the cycle after grant.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_data);
    issue(OPC_LOAD, f3, addr, 32'h0, 5'd5);
    tick();
    i_valid = 1'b0;
    chk({tag, "_req"}, 32'(o_mem_req), 32'd1);
    chk({tag, "_be"}, 32'(o_mem_be), 32'(exp_be));
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = rdata;
    chk({tag, "_rdy_wait"}, 32'(o_ready), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    chk({tag, "_wbv"}, 32'(o_wb_valid), 32'd1);
    chk({tag, "_data"}, o_wb_data, exp_data);
    chk({tag, "_we"}, 32'(o_wb_we), 32'd1);
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0; i_opcode = '0; i_funct3 = '0; i_addr = '0; i_wdata = '0; i_rd = '0;
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    #12;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_wbv", 32'(o_wb_valid), 32'd0);
    chk("rst_be", 32'(o_mem_be), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // SB at 0x1003
    issue(OPC_STORE, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd7);
    tick();
    i_valid = 1'b0;
    chk("sb_req", 32'(o_mem_req), 32'd1);
    chk("sb_addr", o_mem_addr, 32'h0000_1000);
    chk("sb_be", 32'(o_mem_be), 32'h8);
    chk("sb_wdata", o_mem_wdata, 32'hA5A5_A5A5);
    chk("sb_we", 32'(o_mem_we), 32'd1);
    chk("sb_ready", 32'(o_ready), 32'd0);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    chk("sb_wbv", 32'(o_wb_valid), 32'd1);
    chk("sb_wbwe", 32'(o_wb_we), 32'd0);
    chk("sb_err", 32'(o_err), 32'd0);
    chk("sb_req_drop", 32'(o_mem_req), 32'd0);
    tick();
    chk("sb_wbv_pulse", 32'(o_wb_valid), 32'd0);

    // SH at offset 2
    issue(OPC_STORE, 3'b001, 32'h0000_0102, 32'hCAFE_BEEF, 5'd1);
    tick();
    i_valid = 1'b0;
    chk("sh_be", 32'(o_mem_be), 32'hC);
    chk("sh_wdata", o_mem_wdata, 32'hBEEF_BEEF);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    tick();

    do_load("lb",  3'b000, 32'h0000_2001, 32'h1234_80FF, 4'b0010, 32'hFFFF_FF80);
    tick();
    do_load("lbu", 3'b100, 32'h0000_2001, 32'h1234_80FF, 4'b0010, 32'h0000_0080);
    tick();
    do_load("lh",  3'b001, 32'h0000_2002, 32'h1234_80FF, 4'b1100, 32'h0000_1234);
    tick();
    do_load("lh0", 3'b001, 32'h0000_2000, 32'h1234_80FF, 4'b0011, 32'hFFFF_80FF);
    tick();
    do_load("lhu", 3'b101, 32'h0000_2000, 32'h1234_80FF, 4'b0011, 32'h0000_80FF);
    tick();

    // Misaligned LW
    issue(OPC_LOAD, 3'b010, 32'h0000_2002, 32'h0, 5'd4);
    tick();
    i_valid = 1'b0;
    chk("lwmis_req", 32'(o_mem_req), 32'd0);
    chk("lwmis_wbv", 32'(o_wb_valid), 32'd1);
    chk("lwmis_err", 32'(o_err), 32'd1);
    chk("lwmis_we", 32'(o_wb_we), 32'd0);
    chk("lwmis_ready", 32'(o_ready), 32'd1);
    tick();
    chk("lwmis_err_pulse", 32'(o_err), 32'd0);

    // Illegal funct3 for load and store
    issue(OPC_LOAD, 3'b011, 32'h0, 32'h0, 5'd4);
    tick();
    chk("ill_ld_err", 32'(o_err), 32'd1);
    chk("ill_ld_req", 32'(o_mem_req), 32'd0);
    issue(OPC_STORE, 3'b100, 32'h0, 32'h0, 5'd4);
    tick();
    i_valid = 1'b0;
    chk("ill_st_err", 32'(o_err), 32'd1);
    chk("ill_st_req", 32'(o_mem_req), 32'd0);
    tick();

    // ADD passthrough back-to-back, rd 3 then rd 0
    issue(OPC_ADD, 3'b000, 32'h0000_0055, 32'h0, 5'd3);
    tick();
    chk("add_wbv", 32'(o_wb_valid), 32'd1);
    chk("add_we", 32'(o_wb_we), 32'd1);
    chk("add_rd", 32'(o_wb_rd), 32'd3);
    chk("add_data", o_wb_data, 32'h0000_0055);
    issue(OPC_ADD, 3'b000, 32'h0000_0055, 32'h0, 5'd0);
    tick();
    i_valid = 1'b0;
    chk("add0_wbv", 32'(o_wb_valid), 32'd1);
    chk("add0_we", 32'(o_wb_we), 32'd0);
    tick();

    // Stray gnt/rvalid while idle
    i_mem_gnt = 1'b1; i_mem_rvalid = 1'b1;
    tick();
    i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    chk("stray_wbv", 32'(o_wb_valid), 32'd0);
    chk("stray_req", 32'(o_mem_req), 32'd0);

    // LW with grant stalled 3 cycles and rvalid 2 cycles after grant
    issue(OPC_LOAD, 3'b010, 32'h0000_3000, 32'h0, 5'd9);
    tick();
    i_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_req", 32'(o_mem_req), 32'd1);
      chk("stall_addr", o_mem_addr, 32'h0000_3000);
      chk("stall_ready", 32'(o_ready), 32'd0);
      tick();
    end
    chk("stall_req_g", 32'(o_mem_req), 32'd1);
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    chk("stall_gap_wbv", 32'(o_wb_valid), 32'd0);
    chk("stall_gap_ready", 32'(o_ready), 32'd0);
    tick();
    chk("stall_rv_wbv", 32'(o_wb_valid), 32'd0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    tick();
    i_mem_rvalid = 1'b0;
    chk("stall_ret_wbv", 32'(o_wb_valid), 32'd1);
    chk("stall_ret_data", o_wb_data, 32'hDEAD_BEEF);
    chk("stall_ret_rd", 32'(o_wb_rd), 32'd9);
    chk("stall_ret_ready", 32'(o_ready), 32'd1);
    tick();

    // Reset asserted while waiting for rvalid
    issue(OPC_LOAD, 3'b010, 32'h0000_4000, 32'h0, 5'd2);
    tick();
    i_valid = 1'b0;
    i_mem_gnt = 1'b1;
    tick();
    i_mem_gnt = 1'b0;
    chk("rstw_ready_pre", 32'(o_ready), 32'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rstw_ready", 32'(o_ready), 32'd1);
    chk("rstw_addr", o_mem_addr, 32'h0);
    chk("rstw_be", 32'(o_mem_be), 32'd0);
    tick();
    i_rst_n = 1'b1;
    tick();
    chk("rstw_wbv", 32'(o_wb_valid), 32'd0);
    chk("rstw_ready_rel", 32'(o_ready), 32'd1);
    tick();
    chk("rstw_wbv2", 32'(o_wb_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
